// File: rtl/sine_nco_pkg.sv
// Shared types and default sizing for the sine NCO sequencer slice.
package sine_nco_pkg;

    localparam int PHASE_WIDTH_DEF    = 32;
    localparam int BIT_WIDTH_DEF      = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } nco_state_t;

endpackage

// File: rtl/sine_nco_if.sv
// Sine core handshake plus output sample stream, seen from the sequencer (master) side.
interface sine_nco_if
    import sine_nco_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF
);
    logic                        core_start;
    logic [BIT_WIDTH-1:0]        core_angle;
    logic                        core_ready;
    logic                        core_done;
    logic signed [BIT_WIDTH-1:0] core_value;
    logic signed [BIT_WIDTH-1:0] sample_out;
    logic                        sample_valid;
    logic                        sample_ready;

    modport master (
        output core_start, core_angle, sample_out, sample_valid,
        input  core_ready, core_done, core_value, sample_ready
    );

    modport slave (
        input  core_start, core_angle, sample_out, sample_valid,
        output core_ready, core_done, core_value, sample_ready
    );
endinterface

// File: rtl/sample_fifo2.sv
// Two-entry in-order FIFO with synchronous reset; head is the oldest entry.
module sample_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sine_nco_sequencer.sv
// Phase accumulator + issue/wait sequencer for the sine core, buffering results in a 2-entry FIFO.
//   state    | meaning
//   ST_IDLE  | stopped; waits for enable
//   ST_ISSUE | waiting for core_ready and a free FIFO slot to launch a sample
//   ST_WAIT  | one computation in flight; waits for core_done or timeout
module sine_nco_sequencer
    import sine_nco_pkg::*;
#(
    parameter int PHASE_WIDTH    = PHASE_WIDTH_DEF,
    parameter int BIT_WIDTH      = BIT_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic                   phase_load,
    input  logic [PHASE_WIDTH-1:0] phase_init,
    output logic                   busy,
    output logic                   error,
    sine_nco_if.master             bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    nco_state_t             state;
    nco_state_t             state_next;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   start_q;
    logic [BIT_WIDTH-1:0]   angle_q;
    logic [TW-1:0]          tmo_cnt;
    logic                   error_q;

    logic                   issue;
    logic                   push;
    logic                   tmo_hit;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [BIT_WIDTH-1:0]   fifo_head;
    logic                   can_issue;

    // A pop this cycle frees a slot, so issue may proceed in the same cycle.
    assign pop       = !fifo_empty && bus.sample_ready;
    assign can_issue = !fifo_full || pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (bus.core_ready && can_issue) begin
                    issue      = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    push       = 1'b1;
                    state_next = enable ? ST_ISSUE : ST_IDLE;
                end else if (tmo_cnt == '0) begin
                    tmo_hit    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= '0;
            start_q <= 1'b0;
            angle_q <= '0;
            tmo_cnt <= '0;
            error_q <= 1'b0;
        end else begin
            start_q <= issue;
            if (issue) begin
                angle_q <= phase[PHASE_WIDTH-1 -: BIT_WIDTH];
            end
            // A load wins over the increment and is used unmodified.
            if (phase_load) begin
                phase <= phase_init;
            end else if (issue) begin
                phase <= phase + freq_word;
            end
            if (issue || push) begin
                tmo_cnt <= TW'(TIMEOUT_CYCLES);
            end else if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt - TW'(1);
            end
            if (tmo_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    sample_fifo2 #(
        .WIDTH (BIT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.core_value),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.core_start   = start_q;
    assign bus.core_angle   = angle_q;
    assign bus.sample_out   = fifo_head;
    assign bus.sample_valid = !fifo_empty;
    assign busy             = (state == ST_ISSUE) || (state == ST_WAIT);
    assign error            = error_q;
endmodule

// File: tb/tb_sine_nco_sequencer.sv
// Directed bench for sine_nco_sequencer with a fixed-latency sine core model.
module tb_sine_nco_sequencer;
    localparam int PW  = 32;
    localparam int BW  = 16;
    localparam int TMO = 64;
    localparam int LAT = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          phase_load = 1'b0;
    logic [PW-1:0] freq_word = '0;
    logic [PW-1:0] phase_init = '0;
    logic          busy;
    logic          error;

    sine_nco_if #(.BIT_WIDTH(BW)) bus ();

    sine_nco_sequencer #(
        .PHASE_WIDTH    (PW),
        .BIT_WIDTH      (BW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .freq_word  (freq_word),
        .phase_load (phase_load),
        .phase_init (phase_init),
        .busy       (busy),
        .error      (error),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start = 0;

    bit            hang = 1'b0;
    bit            inject_done = 1'b0;
    bit            m_busy;
    int            m_cnt;
    logic [BW-1:0] m_angle;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.core_start) n_start <= n_start + 1;
    end

    // Core model: done arrives LAT cycles after the start cycle; result = angle ^ 0x1234.
    always @(posedge clk) begin
        if (reset) begin
            m_busy          <= 1'b0;
            m_cnt           <= 0;
            m_angle         <= '0;
            bus.core_ready  <= 1'b1;
            bus.core_done   <= 1'b0;
            bus.core_value  <= '0;
        end else begin
            bus.core_done <= inject_done;
            if (inject_done) bus.core_value <= 16'sh7777;
            if (bus.core_start) begin
                m_busy         <= 1'b1;
                m_cnt          <= LAT - 1;
                m_angle        <= bus.core_angle;
                bus.core_ready <= 1'b0;
            end else if (m_busy && !hang) begin
                if (m_cnt == 1) begin
                    bus.core_done  <= 1'b1;
                    bus.core_value <= $signed(m_angle ^ 16'h1234);
                    m_busy         <= 1'b0;
                    bus.core_ready <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.core_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        enable           = 1'b0;
        phase_load       = 1'b0;
        hang             = 1'b0;
        inject_done      = 1'b0;
        bus.sample_ready = 1'b0;
        freq_word        = '0;
        phase_init       = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        bus.sample_ready = 1'b0;
        tick(3);
        checks++;
        if ({busy, error, bus.core_start, bus.sample_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy/error/start/valid=%b expected 0000",
                     {busy, error, bus.core_start, bus.sample_valid});
        end
        checks++;
        if (bus.core_angle !== 16'h0000) begin
            errors++;
            $display("FAIL reset_angle: got %h expected 0000", bus.core_angle);
        end
        checks++;
        if (bus.sample_out !== 16'sh0000) begin
            errors++;
            $display("FAIL reset_sample: got %h expected 0000", bus.sample_out);
        end
        reset  = 1'b0;
        enable = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        logic [BW-1:0] exp_ang [5];
        bit ok;
        int prev;
        int n0;
        exp_ang = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
        prev = 0;
        do_reset();
        freq_word  = 32'h4000_0000;
        phase_init = 32'h0;
        phase_load = 1'b1;
        tick(1);
        phase_load = 1'b0;
        bus.sample_ready = 1'b1;
        n0 = n_start;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_start(40, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL basic_start_timeout: sample %0d got no core_start expected one", i);
                break;
            end
            checks++;
            if (bus.core_angle !== exp_ang[i]) begin
                errors++;
                $display("FAIL basic_angle: sample %0d got %h expected %h", i, bus.core_angle, exp_ang[i]);
            end
            if (i > 0) begin
                checks++;
                if (cyc - prev != 20) begin
                    errors++;
                    $display("FAIL basic_period: sample %0d got %0d cycles expected 20", i, cyc - prev);
                end
            end
            prev = cyc;
            if (i == 4) enable = 1'b0;
            tick(LAT);
            checks++;
            if (bus.sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_valid: sample %0d got valid=%b expected 0", i, bus.sample_valid);
            end
            tick(1);
            checks++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== $signed(exp_ang[i] ^ 16'h1234)) begin
                errors++;
                $display("FAIL basic_sample: sample %0d got valid=%b data=%h expected valid=1 data=%h",
                         i, bus.sample_valid, bus.sample_out, exp_ang[i] ^ 16'h1234);
            end
        end
        tick(30);
        checks++;
        if (n_start - n0 != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_start_count: got starts=%0d busy=%b expected starts=5 busy=0", n_start - n0, busy);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        do_reset();
        freq_word = 32'h4000_0000;
        bus.sample_ready = 1'b0;
        n0 = n_start;
        enable = 1'b1;
        tick(80);
        checks++;
        if (n_start - n0 != 2) begin
            errors++;
            $display("FAIL bp_start_count: got %0d starts expected 2", n_start - n0);
        end
        checks++;
        if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'sh1234 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_head: got valid=%b data=%h busy=%b expected valid=1 data=1234 busy=1",
                     bus.sample_valid, bus.sample_out, busy);
        end
        bus.sample_ready = 1'b1;
        tick(1);
        bus.sample_ready = 1'b0;
        checks++;
        if (bus.core_start !== 1'b1 || bus.core_angle !== 16'h8000) begin
            errors++;
            $display("FAIL bp_resume: got start=%b angle=%h expected start=1 angle=8000",
                     bus.core_start, bus.core_angle);
        end
        checks++;
        if (bus.sample_out !== 16'sh5234) begin
            errors++;
            $display("FAIL bp_pop_head: got %h expected 5234", bus.sample_out);
        end
        tick(25);
        checks++;
        if (n_start - n0 != 3) begin
            errors++;
            $display("FAIL bp_refill_count: got %0d starts expected 3", n_start - n0);
        end
        bus.sample_ready = 1'b1;
        tick(1);
        bus.sample_ready = 1'b0;
        checks++;
        if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'sh9234) begin
            errors++;
            $display("FAIL bp_order: got valid=%b data=%h expected valid=1 data=9234",
                     bus.sample_valid, bus.sample_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_load_wait();
        bit ok;
        do_reset();
        freq_word = 32'h4000_0000;
        bus.sample_ready = 1'b1;
        enable = 1'b1;
        wait_start(10, ok);
        checks++;
        if (!ok || bus.core_angle !== 16'h0000) begin
            errors++;
            $display("FAIL load_first: got ok=%b angle=%h expected ok=1 angle=0000", ok, bus.core_angle);
        end
        tick(2);
        phase_init = 32'h8000_0000;
        phase_load = 1'b1;
        tick(1);
        phase_load = 1'b0;
        tick(16);
        checks++;
        if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'sh1234) begin
            errors++;
            $display("FAIL load_inflight: got valid=%b data=%h expected valid=1 data=1234",
                     bus.sample_valid, bus.sample_out);
        end
        wait_start(10, ok);
        checks++;
        if (!ok || bus.core_angle !== 16'h8000) begin
            errors++;
            $display("FAIL load_next: got ok=%b angle=%h expected ok=1 angle=8000", ok, bus.core_angle);
        end
        enable = 1'b0;
        wait_start(30, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL load_stop: got extra core_start expected none");
        end
        enable = 1'b1;
        wait_start(10, ok);
        checks++;
        if (!ok || bus.core_angle !== 16'hC000) begin
            errors++;
            $display("FAIL load_after: got ok=%b angle=%h expected ok=1 angle=C000", ok, bus.core_angle);
        end
        enable = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        hang = 1'b1;
        freq_word = 32'h4000_0000;
        bus.sample_ready = 1'b1;
        enable = 1'b1;
        wait_start(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_start: got no core_start expected one");
        end
        tick(TMO);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: got error=%b expected 0", error);
        end
        tick(1);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || bus.sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_hit: got error=%b busy=%b valid=%b expected 1 0 0",
                     error, busy, bus.sample_valid);
        end
        enable = 1'b0;
        tick(20);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: got error=%b expected 1", error);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: got error=%b expected 0", error);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int n0;
        do_reset();
        freq_word = 32'h1000_0000;
        bus.sample_ready = 1'b1;
        n0 = n_start;
        enable = 1'b1;
        wait_start(10, ok);
        tick(3);
        enable = 1'b0;
        tick(16);
        checks++;
        if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'sh1234) begin
            errors++;
            $display("FAIL drop_deliver: got valid=%b data=%h expected valid=1 data=1234",
                     bus.sample_valid, bus.sample_out);
        end
        tick(40);
        checks++;
        if (n_start - n0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_issue: got starts=%0d busy=%b expected starts=1 busy=0", n_start - n0, busy);
        end
        inject_done = 1'b1;
        tick(1);
        inject_done = 1'b0;
        tick(1);
        checks++;
        if (bus.sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_stray_done: got valid=%b expected 0", bus.sample_valid);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_reset();
        phase_init = 32'h2468_0000;
        phase_load = 1'b1;
        tick(1);
        phase_load = 1'b0;
        bus.sample_ready = 1'b1;
        enable = 1'b1;
        wait_start(10, ok);
        checks++;
        if (!ok || bus.core_angle !== 16'h2468) begin
            errors++;
            $display("FAIL mid_angle: got ok=%b angle=%h expected ok=1 angle=2468", ok, bus.core_angle);
        end
        tick(5);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({busy, error, bus.core_start, bus.sample_valid} !== 4'b0000 ||
            bus.core_angle !== 16'h0000 || bus.sample_out !== 16'sh0000) begin
            errors++;
            $display("FAIL mid_reset: got busy/error/start/valid=%b angle=%h data=%h expected 0000 0000 0000",
                     {busy, error, bus.core_start, bus.sample_valid}, bus.core_angle, bus.sample_out);
        end
        reset  = 1'b0;
        enable = 1'b0;
        inject_done = 1'b1;
        tick(1);
        inject_done = 1'b0;
        tick(1);
        checks++;
        if (bus.sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_late_done: got valid=%b expected 0", bus.sample_valid);
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_start(30, ok);
            checks++;
            if (!ok || bus.core_angle !== 16'h0000) begin
                errors++;
                $display("FAIL const_angle: sample %0d got ok=%b angle=%h expected ok=1 angle=0000",
                         i, ok, bus.core_angle);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        bus.sample_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_load_wait();
        test_timeout();
        test_enable_drop();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sine_nco_sequencer.md
# sine_nco_sequencer

Phase-accumulating sample sequencer feeding the CORDIC sine stage. It advances a PHASE_WIDTH-bit phase accumulator by a programmable frequency word and issues one computation per sample to the downstream sine core through its start/ready/done handshake. It captures each result into a 2-entry output FIFO and presents samples on a valid/ready stream. It is the control and buffering stage between the register block and the sine core; the core is instantiated beside it, not inside it.

## Interface
- PHASE_WIDTH, 32, accumulator width; angle = top BIT_WIDTH bits
- BIT_WIDTH, 16, sine core angle/value width
- TIMEOUT_CYCLES, 64, max cycles to wait for core_done before error
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; run sample generation while high
- freq_word  in  PHASE_WIDTH  phase increment per issued sample, unsigned
- phase_load  in  1  one-cycle pulse; load phase_init into accumulator
- phase_init  in  PHASE_WIDTH  value loaded on phase_load
- core_start  out  1  start pulse to sine core
- core_angle  out  BIT_WIDTH  angle to sine core
- core_ready  in  1  sine core ready (registered in core)
- core_done  in  1  sine core done; core_value valid while high
- core_value  in  BIT_WIDTH signed  sine core result
- sample_out  out  BIT_WIDTH signed  FIFO head sample
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  consumer accepts head when high with sample_valid
- busy  out  1  high in ISSUE or WAIT
- error  out  1  sticky; core timeout occurred; cleared only by reset

## Operation
- Reset: phase=0, FSM=IDLE, FIFO empty; core_start=0, core_angle=0, sample_out=0, sample_valid=0, busy=0, error=0.
- FSM states IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when enable=1.
- In ISSUE, when enable=1, core_ready=1 and FIFO not full: register core_start=1 and core_angle=phase[PHASE_WIDTH-1 -: BIT_WIDTH], set phase += freq_word (mod 2^PHASE_WIDTH), then go to WAIT. Otherwise hold in ISSUE. If enable=0 while in ISSUE, go to IDLE.
- core_start is high for exactly one cycle per issue. core_angle is held stable until the capture.
- WAIT: on core_done=1, push core_value into the FIFO and reset the timeout counter. Go to ISSUE if enable=1, else IDLE. The block does not re-issue during WAIT, even though core_ready may still read high for one cycle after start.
- WAIT timeout: after TIMEOUT_CYCLES cycles without core_done, set error=1, discard the computation, go to IDLE.
- core_done outside WAIT is ignored.
- phase_load has priority over the increment in the same cycle; the loaded value is used as-is (no increment). A computation already in flight completes and is delivered normally.
- enable dropped during WAIT: the in-flight result is still captured, then the FSM goes to IDLE.
- FIFO: 2 entries, in order. A pop happens when sample_valid && sample_ready. Simultaneous push and pop at count 1 leaves count 1 and the new sample becomes head. Because issue requires not-full and at most one computation is in flight, overflow cannot occur.
- freq_word=0 yields a constant angle; wrap-around of phase is silent.

## Timing
- Core handshake: enable high at edge k gives IDLE->ISSUE at k, then core_start high in cycle k+1 (if ready and not full).
- Core done to FIFO: core_done high in cycle c gives sample_valid high in cycle c+1 (if FIFO was empty).
- Output pop: sample_out updates the cycle after a pop.
- Throughput: one sample per core latency + 2 cycles, assuming no backpressure.
- Backpressure stall: FIFO full stalls issue; issue resumes the cycle after the pop that frees a slot.
- Reset mid-WAIT: everything returns to reset values next cycle; a late core_done is ignored.

## Structure
- Shared package `sine_nco_pkg`:
  - FSM state enum.
  - Default PHASE_WIDTH, BIT_WIDTH and TIMEOUT_CYCLES constants.
- One sub-module: `sample_fifo2`, a 2-entry synchronous FIFO parameterized by width, with push, pop, full, empty, head, and synchronous reset.
- Accumulator, FSM and timeout counter live in the top module.

## Test plan
- Basic sequencing: reset, phase_init=0, freq_word=0x4000_0000, enable=1, core model latency 18 cycles, sample_ready=1 -> core_angle sequence 0x0000, 0x4000, 0x8000, 0xC000, 0x0000. Check one core_start per sample and a 20-cycle sample period.
- Backpressure: sample_ready=0 -> exactly 2 samples buffered and no further core_start. Raise sample_ready for one cycle -> one pop, then a new core_start the next cycle; FIFO order preserved.
- Load during WAIT: phase_load with phase_init=0x8000_0000 while in WAIT -> in-flight sample delivered unchanged, next core_angle=0x8000.
- Timeout: core model never asserts done -> error=1 at TIMEOUT_CYCLES+1 cycles after start, FSM IDLE, no FIFO push. error stays high until reset.
- Enable drop: enable falls during WAIT -> that result is delivered, then no further core_start. A stray core_done in IDLE pushes nothing.
- Mid-operation reset: reset asserted in WAIT -> all outputs at reset values next cycle; a subsequent core_done is ignored.
